posit_round_encode: RTL and testbench
=====================================

# posit_round_encode

Registered rounding-and-packing stage. It converts an unpacked posit (sign, zero/inf flags, biased exponent, fraction) plus two extra trailing bits and a sticky bit into a WIDTH-bit packed posit. Rounding is round-to-nearest-even in the encoded bit string. It sits at the tail of arithmetic datapaths (log/linear converters, adders, multipliers) and is the last step before a value is stored or emitted.

## Interface
Parameters:
- WIDTH, 8: packed posit width N, ≥ 4.
- ES, 1: posit exponent field size, ≥ 0; WIDTH-3-ES ≥ 0.
- Derived BIAS = (WIDTH-2)·2^ES.
- Derived FRAC_BITS = WIDTH-3-ES.
- Derived EXP_BITS = clog2(2·BIAS+1).

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- inValid  in  1  input sample valid.
- inSign  in  1  1 = negative.
- inIsZero  in  1  value is zero.
- inIsInf  in  1  value is NaR/infinity.
- inExponent  in  EXP_BITS  unsigned biased exponent, legal range 0..2·BIAS.
- inFraction  in  FRAC_BITS  fraction bits below the hidden 1, MSB first.
- trailingBits  in  2  next two fraction bits below inFraction.
- stickyBit  in  1  OR of all fraction bits below trailingBits.
- outValid  out  1  outBits holds a new result.
- outBits  out  WIDTH  packed posit, two's-complement encoded.

## Operation
- Special cases take priority over rounding, and inIsInf wins over inIsZero:
  - inIsInf → outBits = 1 followed by WIDTH-1 zeros (NaR), regardless of sign.
  - inIsZero → all zeros, regardless of sign.
- Otherwise compute signed exponent s = inExponent − BIAS.
  - Regime k = floor(s / 2^ES), arithmetic shift.
  - Exponent field e = s mod 2^ES.
- Build the unsigned magnitude string, MSB first:
  - regime: k ≥ 0 gives k+1 ones then a 0; k < 0 gives −k zeros then a 1;
  - then the ES bits of e;
  - then inFraction;
  - then trailingBits.
- Keep the first WIDTH-1 bits as magnitude m, zero-padding on the right if the string is shorter.
- Rounding bits:
  - guard g = first dropped bit;
  - sticky t = OR of all remaining dropped bits OR stickyBit.
- Round up (m+1) iff g & (t | m[0]).
- Saturation:
  - If the increment would exceed 0111…1, result = maxpos (WIDTH-1 ones).
  - Nonzero finite input never yields 0; the minimum result magnitude is 0…01.
- inExponent > 2·BIAS is clamped to maxpos. The minimum exponent (0) encodes exactly minpos.
- Final output = {0, m} if sign is 0; otherwise the two's complement of {0, m}.
- Datapath is combinational from inputs to a single output register. No internal state beyond that register.

## Timing
- Latency 1 cycle: inputs sampled at edge n appear on outBits/outValid after edge n.
- Full throughput: one new input accepted per cycle; no backpressure.
- When inValid = 1: outValid ← 1 and outBits ← encoded result.
- When inValid = 0: outValid ← 0 and outBits holds its previous value.
- Reset asserted (asynchronous): outValid = 0 and outBits = 0 immediately, held until the first edge after deassertion.
- Reset mid-stream drops the in-flight result.

## Test plan
WIDTH=8, ES=1, so BIAS=12, FRAC_BITS=4, EXP_BITS=5.
1. Specials:
   - isZero=1 (sign 0 or 1) → 0x00.
   - isInf=1 (any sign, including with isZero=1) → 0x80.
   - Both land one cycle after inValid, with outValid=1.
2. Exact values with trailing=00, sticky=0:
   - exp=12, frac=0000 → 0x40 (+1.0); same with sign=1 → 0xC0.
   - exp=12, frac=0001 → 0x41.
3. Round-to-nearest-even ties:
   - exp=12, frac=0001, trailing=10 → 0x42.
   - exp=12, frac=0000, trailing=10 → 0x40.
   - exp=12, frac=0000, trailing=10, sticky=1 → 0x41.
4. Extremes:
   - exp=24 → 0x7F; sign=1 → 0x81.
   - exp=23, frac=0, trailing=00: sticky=0 → 0x7E; sticky=1 → 0x7F.
   - exp=0 → 0x01; sign=1 → 0xFF.
   - exp=31 → 0x7F (clamp).
5. Throughput/reset:
   - Back-to-back valid inputs produce back-to-back outputs.
   - Assert reset mid-stream → outValid and outBits go to 0 without a clock edge.
   - After release, the next valid input is encoded correctly.

Source files
------------

// File: rtl/posit_round_encode.sv
// Rounding and packing stage: turns an unpacked posit into a WIDTH-bit packed posit.
// It uses round-to-nearest-even on the encoded bit string and has one output register.
module posit_round_encode #(
  parameter int WIDTH     = 8,
  parameter int ES        = 1,
  parameter int BIAS      = (WIDTH - 2) * (2 ** ES),
  parameter int FRAC_BITS = WIDTH - 3 - ES,
  parameter int EXP_BITS  = $clog2(2 * BIAS + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inValid,
  input  logic                 inSign,
  input  logic                 inIsZero,
  input  logic                 inIsInf,
  input  logic [EXP_BITS-1:0]  inExponent,
  input  logic [FRAC_BITS-1:0] inFraction,
  input  logic [1:0]           trailingBits,
  input  logic                 stickyBit,
  output logic                 outValid,
  output logic [WIDTH-1:0]     outBits
);

  localparam int SW   = EXP_BITS + 1;
  localparam int ESW  = (ES > 0) ? ES : 1;
  localparam int TB   = ES + FRAC_BITS + 2;
  localparam int SL   = WIDTH + TB;
  localparam logic signed [SW-1:0] BIAS_S = SW'(BIAS);
  localparam logic [EXP_BITS-1:0]  EMAX   = EXP_BITS'(2 * BIAS);

  logic signed [SW-1:0] sExp;
  logic signed [SW-1:0] regime;
  logic [SW-1:0]        runLen;
  logic [ESW-1:0]       eField;
  logic [SL-1:0]        seed;
  logic [SL-1:0]        onesMask;
  logic [SL-1:0]        bitString;
  logic [WIDTH-2:0]     mag;
  logic [WIDTH-2:0]     magRounded;
  logic                 guardBit;
  logic                 stickyAll;
  logic [WIDTH-1:0]     unsignedBits;
  logic [WIDTH-1:0]     encoded;

  always_comb begin
    sExp     = $signed({1'b0, inExponent}) - BIAS_S;
    regime   = sExp >>> ES;
    eField   = sExp[ESW-1:0];
    runLen   = regime[SW-1] ? SW'(-regime) : SW'(regime + SW'(1));

    // The regime terminator sits at the top and the tail follows it.
    // Shifting right by the run length opens a gap at the top:
    // zeros for a negative regime, ones (through the mask) for a non-negative one.
    seed = '0;
    seed[SL-1] = regime[SW-1];
    for (int i = 0; i < ES; i++)
      seed[SL-2-i] = eField[ESW-1-i];
    for (int i = 0; i < FRAC_BITS; i++)
      seed[SL-2-ES-i] = inFraction[FRAC_BITS-1-i];
    seed[SL-2-ES-FRAC_BITS] = trailingBits[1];
    seed[SL-3-ES-FRAC_BITS] = trailingBits[0];

    onesMask  = regime[SW-1] ? '0 : ~({SL{1'b1}} >> runLen);
    bitString = (seed >> runLen) | onesMask;

    mag       = bitString[SL-1 -: WIDTH-1];
    guardBit  = bitString[SL-WIDTH];
    stickyAll = (|bitString[SL-WIDTH-1:0]) | stickyBit;

    magRounded = mag;
    if (guardBit && (stickyAll || mag[0]) && !(&mag))
      magRounded = mag + (WIDTH-1)'(1);
    if (inExponent > EMAX)
      magRounded = '1;
    if (magRounded == '0)
      magRounded = (WIDTH-1)'(1);

    unsignedBits = {1'b0, magRounded};
    encoded = inSign ? (~unsignedBits + WIDTH'(1)) : unsignedBits;
    if (inIsZero)
      encoded = '0;
    if (inIsInf)
      encoded = {1'b1, {(WIDTH-1){1'b0}}};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outValid <= 1'b0;
      outBits  <= '0;
    end else begin
      outValid <= inValid;
      if (inValid)
        outBits <= encoded;
    end
  end

endmodule

// File: tb/tb_posit_round_encode.sv
// Scoreboard bench for posit_round_encode with WIDTH=8 and ES=1.
// Stimulus pushes hand-computed expectations, and a negedge monitor pops and compares them.
module tb_posit_round_encode;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       inValid = 1'b0;
  logic       inSign = 1'b0;
  logic       inIsZero = 1'b0;
  logic       inIsInf = 1'b0;
  logic [4:0] inExponent = '0;
  logic [3:0] inFraction = '0;
  logic [1:0] trailingBits = '0;
  logic       stickyBit = 1'b0;
  logic       outValid;
  logic [7:0] outBits;

  logic [7:0] sb[$];
  int checkCount = 0;
  int passCount = 0;

  posit_round_encode #(.WIDTH(8), .ES(1)) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inSign(inSign),
    .inIsZero(inIsZero), .inIsInf(inIsInf), .inExponent(inExponent),
    .inFraction(inFraction), .trailingBits(trailingBits), .stickyBit(stickyBit),
    .outValid(outValid), .outBits(outBits)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic s, input logic z, input logic i, input logic [4:0] e,
                               input logic [3:0] f, input logic [1:0] t, input logic st,
                               input logic [7:0] expected, input bit push);
    @(posedge clock);
    #1;
    inValid = 1'b1; inSign = s; inIsZero = z; inIsInf = i;
    inExponent = e; inFraction = f; trailingBits = t; stickyBit = st;
    if (push) sb.push_back(expected);
  endtask

  always @(negedge clock) begin
    if (outValid === 1'b1) begin
      if (sb.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_output: got 0x%02h, expected no output", outBits);
      end else begin
        checkOutput("scoreboard", outBits, sb.pop_front());
      end
    end
  end

  initial begin
    int waitCycles;
    #1 reset = 1'b1;
    #1;
    checkOutput("reset_valid", {7'd0, outValid}, 8'h00);
    checkOutput("reset_bits", outBits, 8'h00);
    @(posedge clock);
    #2 reset = 1'b0;

    // Specials: NaR beats zero regardless of sign.
    applyStimulus(0, 1, 0, 5'd12, 4'h0, 2'b00, 0, 8'h00, 1);
    applyStimulus(1, 1, 0, 5'd12, 4'h0, 2'b00, 0, 8'h00, 1);
    applyStimulus(0, 0, 1, 5'd12, 4'h0, 2'b00, 0, 8'h80, 1);
    applyStimulus(1, 1, 1, 5'd12, 4'h0, 2'b00, 0, 8'h80, 1);
    // Exact values.
    applyStimulus(0, 0, 0, 5'd12, 4'h0, 2'b00, 0, 8'h40, 1);
    applyStimulus(1, 0, 0, 5'd12, 4'h0, 2'b00, 0, 8'hC0, 1);
    applyStimulus(0, 0, 0, 5'd12, 4'h1, 2'b00, 0, 8'h41, 1);
    applyStimulus(0, 0, 0, 5'd13, 4'h0, 2'b00, 0, 8'h50, 1);
    applyStimulus(0, 0, 0, 5'd11, 4'h0, 2'b00, 0, 8'h30, 1);
    // Ties and sticky.
    applyStimulus(0, 0, 0, 5'd12, 4'h1, 2'b10, 0, 8'h42, 1);
    applyStimulus(0, 0, 0, 5'd12, 4'h0, 2'b10, 0, 8'h40, 1);
    applyStimulus(0, 0, 0, 5'd12, 4'h0, 2'b10, 1, 8'h41, 1);
    applyStimulus(1, 0, 0, 5'd12, 4'h1, 2'b10, 0, 8'hBE, 1);
    // Extremes.
    applyStimulus(0, 0, 0, 5'd24, 4'h0, 2'b00, 0, 8'h7F, 1);
    applyStimulus(1, 0, 0, 5'd24, 4'h0, 2'b00, 0, 8'h81, 1);
    applyStimulus(0, 0, 0, 5'd23, 4'h0, 2'b00, 0, 8'h7E, 1);
    applyStimulus(0, 0, 0, 5'd23, 4'h0, 2'b00, 1, 8'h7F, 1);
    applyStimulus(0, 0, 0, 5'd0,  4'h0, 2'b00, 0, 8'h01, 1);
    applyStimulus(1, 0, 0, 5'd0,  4'h0, 2'b00, 0, 8'hFF, 1);
    applyStimulus(0, 0, 0, 5'd31, 4'h0, 2'b00, 0, 8'h7F, 1);

    // Idle cycle: valid drops and the last result is held.
    @(posedge clock);
    #1 inValid = 1'b0;
    @(posedge clock);
    #2;
    checkOutput("idle_valid", {7'd0, outValid}, 8'h00);
    checkOutput("idle_hold", outBits, 8'h7F);

    // Reset mid-stream: the second sample is in flight and gets dropped.
    applyStimulus(0, 0, 0, 5'd13, 4'h0, 2'b00, 0, 8'h50, 1);
    applyStimulus(1, 0, 0, 5'd12, 4'h0, 2'b00, 0, 8'hC0, 0);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    checkOutput("midreset_valid", {7'd0, outValid}, 8'h00);
    checkOutput("midreset_bits", outBits, 8'h00);
    @(posedge clock);
    #1 inValid = 1'b0;
    checkOutput("held_reset_bits", outBits, 8'h00);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 5'd12, 4'h1, 2'b10, 0, 8'h42, 1);
    @(posedge clock);
    #1 inValid = 1'b0;

    waitCycles = 0;
    while (sb.size() != 0 && waitCycles < 20) begin
      @(posedge clock);
      waitCycles++;
    end
    @(posedge clock);
    checkOutput("scoreboard_drained", 8'(sb.size()), 8'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
